serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing diff = a − b − bin one bit per clock, LSB first, with the running borrow held in a flip-flop between bits. It sits directly upstream of a single-bit full-subtractor cell: it sequences operand bits and the registered borrow into that cell and collects its difference and borrow-out. It provides a compact multi-bit subtract for area-constrained datapaths. It uses a start/busy/done handshake.

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_fs_bit.sv | 22 ++
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Holds the controller state encoding and the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// Single-bit full subtractor cell: d = a ^ b ^ bin, bo = borrow out.
// Purely combinational, no latency, no flow control.
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic ab_x;
  logic ab_borrow;
  logic chain_borrow;

  assign ab_x         = a ^ b;
  assign ab_borrow    = ~a & b;
  // An equal bit pair propagates the incoming borrow unchanged.
  assign chain_borrow = ~ab_x & bin;
  assign d            = ab_x ^ bin;
  assign bo           = ab_borrow | chain_borrow;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first; result after WIDTH RUN edges, done one cycle later clears busy.
// start is only honoured in IDLE; requests while busy are dropped, not queued.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] d_sr_nxt;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             cell_d;
  logic             cell_bo;

  fs_bit u_fs_bit (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (brw),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  generate
    if (WIDTH == 1) begin : g_d_one
      assign d_sr_nxt = cell_d;
    end else begin : g_d_multi
      assign d_sr_nxt = {cell_d, d_sr[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST_CNT) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Flags derive from next state so they stay pure flop outputs.
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      if (load) begin
        a_sr <= a;
        b_sr <= b;
        brw  <= bin;
        cnt  <= '0;
      end else if (step) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        d_sr <= d_sr_nxt;
        brw  <= cell_bo;
        cnt  <= cnt + CW'(1);
      end
      // Result registers move only on completion, so they hold through the next RUN.
      if (last) begin
        diff <= d_sr_nxt;
        bout <= cell_bo;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Expected results come from plain integer subtraction of the operands.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    int         done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start1, bin1, busy1, done1, bout1;
  logic [0:0] a1, b1, diff1;

  exp_t q8[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic bin, input int dc);
    exp_t e;
    int   full;
    full       = int'(a) - int'(b) - int'(bin);
    e.diff     = 8'((full + 1024) % (1 << w));
    e.bout     = (full < 0);
    e.done_cyc = dc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done8_unexpected: done seen with no pending operation (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("diff8", 32'(diff8), 32'(e.diff));
        check("bout8", 32'(bout8), 32'(e.bout));
        check("done8_cycle", cyc, e.done_cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done1_unexpected: done seen with no pending operation (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("diff1", 32'(diff1), 32'(e.diff));
        check("bout1", 32'(bout1), 32'(e.bout));
        check("done1_cycle", cyc, e.done_cyc);
      end
    end
  end

  // Called on a negedge with dut8 idle; returns on the negedge after acceptance.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    q8.push_back(model(8, a, b, bin, cyc + 1 + 8));
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    check("busy8_rise", 32'(busy8), 32'd1);
  endtask

  task automatic wait_done8();
    int t = 0;
    while (done8 !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("done8_timeout", 32'(done8), 32'd1);
  endtask

  task automatic wait_done1();
    int t = 0;
    while (done1 !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("done1_timeout", 32'(done1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic       vc [4];
    va[0] = 8'h5A; vb[0] = 8'h3C; vc[0] = 1'b0;
    va[1] = 8'h00; vb[1] = 8'h01; vc[1] = 1'b0;
    va[2] = 8'h10; vb[2] = 8'h10; vc[2] = 1'b1;
    va[3] = 8'hFF; vb[3] = 8'h00; vc[3] = 1'b1;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_diff8", 32'(diff8), 32'd0);
    check("rst_bout8", 32'(bout8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, back to back at maximum throughput.
    for (int i = 0; i < 4; i++) begin
      issue8(va[i], vb[i], vc[i]);
      wait_done8();
      check("busy8_during_done", 32'(busy8), 32'd1);
      @(negedge clk);
      check("busy8_fall", 32'(busy8), 32'd0);
      check("done8_fall", 32'(done8), 32'd0);
    end

    // Starts during RUN and DONE must be dropped.
    issue8(8'h5A, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("ignore_busy8", 32'(busy8), 32'd0);
    check("ignore_diff8", 32'(diff8), 32'h1E);
    repeat (3) @(negedge clk);
    check("ignore_still_idle8", 32'(busy8), 32'd0);

    // Result hold across a whole second RUN.
    issue8(8'h00, 8'h01, 1'b0);
    for (int t = 0; t < 20 && done8 !== 1'b1; t++) begin
      check("hold_diff8", 32'(diff8), 32'h1E);
      check("hold_bout8", 32'(bout8), 32'd0);
      @(negedge clk);
    end
    check("hold_done8_seen", 32'(done8), 32'd1);
    @(negedge clk);

    // Asynchronous reset in the middle of a run.
    issue8(8'hC3, 8'h21, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q8.delete();
    #1;
    check("arst_busy8", 32'(busy8), 32'd0);
    check("arst_done8", 32'(done8), 32'd0);
    check("arst_diff8", 32'(diff8), 32'd0);
    check("arst_bout8", 32'(bout8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("arst_idle8", 32'(busy8), 32'd0);
    issue8(8'h81, 8'h7F, 1'b1);
    wait_done8();
    @(negedge clk);

    // Random operations with occasional ignored starts mid-run.
    for (int n = 0; n < 40; n++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 6)) @(negedge clk);
        a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
      end
      wait_done8();
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // WIDTH=1 truth table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
      q1.push_back(model(1, {7'd0, v[2]}, {7'd0, v[1]}, v[0], cyc + 2));
      @(negedge clk);
      start1 = 1'b0;
      check("busy1_rise", 32'(busy1), 32'd1);
      wait_done1();
      @(negedge clk);
      check("busy1_fall", 32'(busy1), 32'd0);
    end

    repeat (4) @(negedge clk);
    check("q8_drained", q8.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
